// File: rtl/fetch_queue_if.sv
// Fetch-to-decode instruction queue bundle: fetch pushes instructions in,
// decode reads the oldest entry and steers stall/flush back into the queue.
interface fetch_queue_if #(
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             enq_valid;
  logic [31:0]      instr_f;
  logic [31:0]      pc_plus_4_f;
  logic             enq_ready;
  logic             stall_d;
  logic             flush_d;
  logic             valid_d;
  logic [31:0]      instr_d;
  logic [31:0]      pc_plus_4_d;
  logic [CNT_W-1:0] count;

  // Pipeline side: drives fetch data and decode control, observes the queue.
  modport master (
    output enq_valid, instr_f, pc_plus_4_f, stall_d, flush_d,
    input  enq_ready, valid_d, instr_d, pc_plus_4_d, count
  );

  // Queue side.
  modport slave (
    input  enq_valid, instr_f, pc_plus_4_f, stall_d, flush_d,
    output enq_ready, valid_d, instr_d, pc_plus_4_d, count
  );
endinterface

// File: rtl/fetch_queue.sv
// IF/ID instruction buffer: small FIFO of {instr, pc_plus_4} that absorbs
// decode stalls, drops everything on a redirect and back-pressures the PC.
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  entry_t           head;

  // Ready depends only on registered occupancy, so stall/flush never reach
  // the PC write enable combinationally.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign enq   = bus.enq_valid & ~full & ~bus.flush_d;
  assign deq   = ~empty & ~bus.stall_d & ~bus.flush_d;

  always_comb begin
    // NOTE: default assigned first so the empty path cannot infer a latch.
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr];
    end
  end

  assign bus.enq_ready   = ~full;
  assign bus.valid_d     = ~empty;
  assign bus.instr_d     = head.instr;
  assign bus.pc_plus_4_d = head.pc_plus_4;
  assign bus.count       = count_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; storage is reset too so the nop bubble is clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.flush_d) begin
      // Redirect: queued and in-flight instructions are all wrong-path.
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= '{instr: bus.instr_f, pc_plus_4: bus.pc_plus_4_f};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: hand-derived vector table for the
// directed scenarios, plus a queue scoreboard for wrap, random and reset cases.
module tb_fetch_queue;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct {
    logic             ev;
    logic [31:0]      ins;
    logic [31:0]      pc;
    logic             st;
    logic             fl;
    logic             x_valid;
    logic [31:0]      x_instr;
    logic [31:0]      x_pc;
    logic [CNT_W-1:0] x_count;
    logic             x_ready;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic   clk;
  logic   reset_n;
  int     checks;
  int     errors;
  vec_t   vecs[$];
  ent_t   sb[$];

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    bus.enq_valid   = ev;
    bus.instr_f     = ins;
    bus.pc_plus_4_f = pc;
    bus.stall_d     = st;
    bus.flush_d     = fl;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid_d"},     64'(bus.valid_d),     64'(0));
    check({tag, ".instr_d"},     64'(bus.instr_d),     64'(0));
    check({tag, ".pc_plus_4_d"}, 64'(bus.pc_plus_4_d), 64'(0));
    check({tag, ".count"},       64'(bus.count),       64'(0));
    check({tag, ".enq_ready"},   64'(bus.enq_ready),   64'(1));
  endtask

  task automatic add_vec(input logic ev, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl, input logic x_valid,
                         input logic [31:0] x_instr, input logic [31:0] x_pc,
                         input int x_count, input logic x_ready);
    vecs.push_back('{ev, ins, pc, st, fl, x_valid, x_instr, x_pc, CNT_W'(x_count), x_ready});
  endtask

  // One cycle against the scoreboard: the model advances on the pre-edge
  // inputs, then the DUT is compared just after the edge.
  task automatic sb_cycle(input string tag, input logic ev, input logic [31:0] ins,
                          input logic [31:0] pc, input logic st, input logic fl);
    bit   m_ready;
    bit   m_valid;
    ent_t head;
    m_ready = (sb.size() != DEPTH);
    m_valid = (sb.size() != 0);
    drive(ev, ins, pc, st, fl);
    if (fl) begin
      sb.delete();
    end else begin
      if (m_valid && !st) void'(sb.pop_front());
      if (ev && m_ready) sb.push_back('{ins, pc});
    end
    @(posedge clk);
    #1;
    head = (sb.size() != 0) ? sb[0] : '0;
    check({tag, ".valid_d"},     64'(bus.valid_d),     64'(sb.size() != 0));
    check({tag, ".instr_d"},     64'(bus.instr_d),     64'(head.instr));
    check({tag, ".pc_plus_4_d"}, 64'(bus.pc_plus_4_d), 64'(head.pc));
    check({tag, ".count"},       64'(bus.count),       64'(sb.size()));
    check({tag, ".enq_ready"},   64'(bus.enq_ready),   64'(sb.size() != DEPTH));
    check({tag, ".count_bound"}, 64'(bus.count <= CNT_W'(DEPTH)), 64'(1));
  endtask

  initial begin
    logic [31:0] pc;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 1'b0);

    // Reset held for 3 edges with fetch presenting data.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs($sformatf("reset_hold%0d", i));
    end
    reset_n = 1'b1;

    //        ev   instr          pc+4          st   fl   valid instr_d        pc_d          cnt rdy
    add_vec(1'b1, 32'h2008_0005, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h2008_0005, 32'h0000_0004, 1, 1'b1);
    // Streaming: one in, one out per cycle.
    add_vec(1'b1, 32'h8c08_0001, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h8c08_0001, 32'h0000_0004, 1, 1'b1);
    add_vec(1'b1, 32'h8c08_0002, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h8c08_0002, 32'h0000_0008, 1, 1'b1);
    add_vec(1'b1, 32'h8c08_0003, 32'h0000_000c, 1'b0, 1'b0, 1'b1, 32'h8c08_0003, 32'h0000_000c, 1, 1'b1);
    add_vec(1'b1, 32'h8c08_0004, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'h8c08_0004, 32'h0000_0010, 1, 1'b1);
    add_vec(1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b1);
    // Stall fill A, B; C refused while full, then drained A, B, C.
    add_vec(1'b1, 32'haaaa_0001, 32'h0000_0020, 1'b1, 1'b0, 1'b1, 32'haaaa_0001, 32'h0000_0020, 1, 1'b1);
    add_vec(1'b1, 32'hbbbb_0002, 32'h0000_0024, 1'b1, 1'b0, 1'b1, 32'haaaa_0001, 32'h0000_0020, 2, 1'b0);
    add_vec(1'b1, 32'hcccc_0003, 32'h0000_0028, 1'b1, 1'b0, 1'b1, 32'haaaa_0001, 32'h0000_0020, 2, 1'b0);
    add_vec(1'b1, 32'hcccc_0003, 32'h0000_0028, 1'b0, 1'b0, 1'b1, 32'hbbbb_0002, 32'h0000_0024, 1, 1'b1);
    add_vec(1'b1, 32'hcccc_0003, 32'h0000_0028, 1'b0, 1'b0, 1'b1, 32'hcccc_0003, 32'h0000_0028, 1, 1'b1);
    add_vec(1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b1);
    // Stall on an empty queue is harmless.
    add_vec(1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b1);
    // Fill to full, then flush with an incoming instruction that must vanish.
    add_vec(1'b1, 32'hdddd_0004, 32'h0000_0030, 1'b1, 1'b0, 1'b1, 32'hdddd_0004, 32'h0000_0030, 1, 1'b1);
    add_vec(1'b1, 32'heeee_0005, 32'h0000_0034, 1'b1, 1'b0, 1'b1, 32'hdddd_0004, 32'h0000_0030, 2, 1'b0);
    add_vec(1'b1, 32'hffff_0006, 32'h0000_0038, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1);
    add_vec(1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b1);
    add_vec(1'b1, 32'h1111_0007, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 32'h1111_0007, 32'h0000_0040, 1, 1'b1);
    // Flush with one entry and a stall: flush wins over both.
    add_vec(1'b1, 32'h2222_0008, 32'h0000_0044, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1);
    add_vec(1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].ev, vecs[i].ins, vecs[i].pc, vecs[i].st, vecs[i].fl);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.valid_d", i),     64'(bus.valid_d),     64'(vecs[i].x_valid));
      check($sformatf("vec%0d.instr_d", i),     64'(bus.instr_d),     64'(vecs[i].x_instr));
      check($sformatf("vec%0d.pc_plus_4_d", i), 64'(bus.pc_plus_4_d), 64'(vecs[i].x_pc));
      check($sformatf("vec%0d.count", i),       64'(bus.count),       64'(vecs[i].x_count));
      check($sformatf("vec%0d.enq_ready", i),   64'(bus.enq_ready),   64'(vecs[i].x_ready));
    end

    // Pointer wrap: continuous fetch, stall toggling every 3 cycles.
    sb.delete();
    pc = 32'h0000_1000;
    for (int i = 0; i < 10; i++) begin
      pc = pc + 32'd4;
      sb_cycle($sformatf("wrap%0d", i), 1'b1, 32'h5000_0000 | pc, pc, 1'(((i / 3) % 2) == 1), 1'b0);
    end
    for (int i = 0; i < 3; i++) sb_cycle($sformatf("wrap_drain%0d", i), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 200; i++) begin
      pc = pc + 32'd4;
      sb_cycle($sformatf("rand%0d", i), 1'($urandom_range(0, 3) != 0), $urandom(), pc,
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges while full.
    sb_cycle("pre_ar_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    sb_cycle("pre_ar_fill0", 1'b1, 32'h7777_0001, 32'h0000_0200, 1'b1, 1'b0);
    sb_cycle("pre_ar_fill1", 1'b1, 32'h7777_0002, 32'h0000_0204, 1'b1, 1'b0);
    check("pre_ar.count", 64'(bus.count), 64'(2));
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("async_reset_held");
    reset_n = 1'b1;
    sb.delete();
    sb_cycle("post_ar0", 1'b1, 32'h2008_0005, 32'h0000_0004, 1'b0, 1'b0);
    sb_cycle("post_ar1", 1'b1, 32'h2008_0009, 32'h0000_0008, 1'b1, 1'b0);
    sb_cycle("post_ar2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    sb_cycle("post_ar3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and the decode stage, replacing a plain IF/ID register. It captures the fetched instruction and its PC+4 in a small FIFO, presents the oldest entry to decode, and absorbs decode stalls without freezing fetch. It discards all buffered instructions on a branch or jump redirect. It back-pressures the PC register through `enq_ready`.

## Interface
- `DEPTH`, 2: number of entries; power of two, ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enq_valid` input 1: fetch presents a valid instruction this cycle.
- `instr_f` input 32: instruction word from instruction memory.
- `pc_plus_4_f` input 32: PC+4 of `instr_f`.
- `enq_ready` output 1: queue accepts an entry this cycle; also the PC-register write enable.
- `stall_d` input 1: decode holds its current instruction.
- `flush_d` input 1: redirect (taken branch, `j`, `jal`, `jr`); all queued and incoming instructions are invalid.
- `valid_d` output 1: `instr_d` / `pc_plus_4_d` hold a real instruction.
- `instr_d` output 32: oldest queued instruction; `32'h0000_0000` (nop) when empty.
- `pc_plus_4_d` output 32: PC+4 of `instr_d`; 0 when empty.
- `count` output $clog2(DEPTH+1): current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {instr, pc_plus_4}, plus read pointer, write pointer and occupancy counter.
- Pointer width is $clog2(DEPTH); both pointers wrap modulo DEPTH.
- `enq_ready = (count != DEPTH)`. This is purely registered state, with no combinational path from `stall_d` or `flush_d`.
- `enq = enq_valid & enq_ready & ~flush_d`.
- `deq = valid_d & ~stall_d & ~flush_d`.
- `valid_d = (count != 0)`.
- Outputs `instr_d` and `pc_plus_4_d` are a combinational mux of the entry at the read pointer. They are forced to 0 when `count == 0`, so decode sees a nop bubble.
- `enq` writes the entry at the write pointer, then increments the write pointer.
- `deq` increments the read pointer.
- `count` update:
  - `+1` on enq only.
  - `-1` on deq only.
  - Unchanged when both or neither occur.
- Simultaneous enq and deq when full cannot occur, because `enq_ready = 0` when full.
- Flush has priority over enq and deq:
  - Next cycle: `count = 0`, read and write pointers = 0.
  - The same-cycle `instr_f` is dropped.
  - Storage contents are don't-care.
- Stall with empty queue: no effect; the queue keeps filling up to DEPTH.
- Enqueue while `count == DEPTH - 1` while decode stalls: the queue becomes full and `enq_ready` drops the next cycle.
- Reset asserted at any time: state clears immediately (asynchronous). This includes mid-stall and mid-flush.
- Reset values:
  - `count = 0`, pointers = 0, storage = 0.
  - Therefore `valid_d = 0`, `instr_d = 0`, `pc_plus_4_d = 0`, `enq_ready = 1`.

## Timing
- Latency is one cycle: an instruction enqueued at edge N appears on `instr_d` with `valid_d = 1` after edge N. This is identical to a plain IF/ID register when the queue stays empty.
- Throughput is one instruction per cycle in steady state: enq and deq in the same cycle leave `count` unchanged.
- `enq_ready` updates the cycle after `count` reaches DEPTH.
- `enq_ready` reasserts the cycle after the first deq from full.
- A flush asserted in cycle N gives `valid_d = 0` from cycle N+1. Fetch restarts from the redirected PC that is loaded at the same edge.
- Reset deassertion is synchronized externally. The first enqueue is accepted on the first edge after `reset_n` rises.

## Test plan
- **Reset:** hold `reset_n = 0` for 3 cycles with `enq_valid = 1` → `valid_d = 0`, `instr_d = 0`, `count = 0`, `enq_ready = 1`. Release, then enqueue `instr_f = 32'h2008_0005`, `pc_plus_4_f = 32'h4` → next cycle `instr_d = 32'h2008_0005`, `pc_plus_4_d = 4`, `valid_d = 1`.
- **Streaming:** enqueue 4 consecutive instructions at PC+4 = 4, 8, 12, 16 with `stall_d = 0` → `instr_d` follows one cycle later, `count` stays 1, `enq_ready` stays 1.
- **Stall fill:** `stall_d = 1` while enqueuing A, B, C (`DEPTH = 2`) → `count` goes 1 then 2; `enq_ready = 0` after the 2nd enqueue; C is held at fetch; `instr_d = A` throughout. Release stall → `instr_d` shows A, then B, then C with no loss or duplication.
- **Flush with simultaneous enqueue:** with `count = 2` and `enq_valid = 1`, assert `flush_d` for 1 cycle → next cycle `count = 0`, `valid_d = 0`, `instr_d = 0`. The incoming instruction is not seen on `instr_d` afterward.
- **Pointer wrap:** 10 enqueue/dequeue cycles with `stall_d` toggling every 3 cycles → the order of `pc_plus_4_d` exactly matches enqueue order across wrap, and `count` never exceeds 2.
- **Asynchronous reset mid-operation:** assert `reset_n = 0` between clock edges while `count = 2` → outputs return to reset values before the next edge.
